// File: rtl/led_fader_pkg.sv
// Shared types, sizing helpers and default-build constants for the LED fader.
// The helpers let each instance derive its own counter sizes from its parameters.
package led_fader_defs;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RISE = 2'd1,
    ON   = 2'd2,
    FALL = 2'd3
  } state_e;

  function automatic int clog2(input longint v);
    int     r;
    longint x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Counter width for a modulus of n; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : clog2(longint'(n));
  endfunction

  // 64-bit intermediates: clk_khz*ramp_us overflows 32 bits at default settings.
  function automatic int presc_f(input int clk_khz, input int pwm_hz, input int bits);
    longint p;
    p = (longint'(clk_khz) * longint'(1000)) / (longint'(pwm_hz) << bits);
    return (p < 1) ? 1 : int'(p);
  endfunction

  function automatic int step_f(input int clk_khz, input int ramp_us, input int bits);
    longint p;
    p = ((longint'(clk_khz) * longint'(ramp_us)) / longint'(1000)) /
        ((longint'(1) << bits) - longint'(1));
    return (p < 1) ? 1 : int'(p);
  endfunction

  localparam int MAX         = (1 << 8) - 1;
  localparam int PRESC       = presc_f(50000, 1000, 8);
  localparam int STEP_CYCLES = step_f(50000, 200000, 8);
  localparam int PRESC_W     = cnt_w(PRESC);
  localparam int STEP_W      = cnt_w(STEP_CYCLES);

endpackage

// File: rtl/led_fader_pwm.sv
// PWM generator: prescaled period counter, duty shadow reloaded only at period wrap,
// registered compare output (one cycle behind the counter); no backpressure.
module led_fader_pwm
  import led_fader_defs::*;
#(
  parameter int PWM_BITS = 8,
  parameter int PRESC    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm_out
);

  localparam int                PW   = cnt_w(PRESC);
  localparam logic [PWM_BITS-1:0] PMAX = '1;

  logic [PW-1:0]       presc_q, presc_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] shadow_q, shadow_d;
  logic                out_q, out_d;
  logic                tc, wrap;

  assign tc   = (presc_q == PW'(PRESC - 1));
  assign wrap = tc && (cnt_q == PMAX);

  always_comb begin
    presc_d  = tc ? '0 : presc_q + 1'b1;
    cnt_d    = tc ? cnt_q + 1'b1 : cnt_q;
    shadow_d = wrap ? duty : shadow_q;
    // Full-scale duty must be solid on, which the plain compare cannot reach.
    out_d    = (shadow_q == PMAX) || (cnt_q < shadow_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q  <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      out_q    <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
    end
  end

  assign pwm_out = out_q;

endmodule

// File: rtl/led_fader.sv
// LED fader: ramps brightness toward led_in one step per STEP_CYCLES and drives the pin via PWM.
// State follows led_in after 1 cycle; no backpressure. LED_FADER_GAMMA_EN selects squared duty mapping.
module led_fader
  import led_fader_defs::*;
#(
  parameter int CLK_FREQ_KHz = 50000,
  parameter int PWM_FREQ_Hz  = 1000,
  parameter int PWM_BITS     = 8,
  parameter int RAMP_US      = 200000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                led_in,
  output logic                led_out,
  output logic [PWM_BITS-1:0] level,
  output logic                busy
);

  localparam int N_PRESC = presc_f(CLK_FREQ_KHz, PWM_FREQ_Hz, PWM_BITS);
  localparam int N_STEP  = step_f(CLK_FREQ_KHz, RAMP_US, PWM_BITS);
  localparam int SW      = cnt_w(N_STEP);
  localparam logic [PWM_BITS-1:0] LVL_MAX = '1;
  localparam logic [PWM_BITS-1:0] LVL_ONE = 1;

  state_e              state_q, state_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [SW-1:0]       step_q, step_d;
  logic                busy_q, busy_d;
  logic                tick;
  logic [PWM_BITS-1:0] duty;

  assign tick = ((state_q == RISE) || (state_q == FALL)) && (step_q == SW'(N_STEP - 1));

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    step_d  = '0;
    unique case (state_q)
      OFF:  if (led_in) state_d = RISE;
      ON:   if (!led_in) state_d = FALL;
      RISE: begin
        // Reversal beats a coincident tick; ends saturate rather than wrap.
        if (!led_in) begin
          state_d = FALL;
        end else if (tick) begin
          if (level_q >= LVL_MAX - 1'b1) begin
            level_d = LVL_MAX;
            state_d = ON;
          end else begin
            level_d = level_q + 1'b1;
          end
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      FALL: begin
        if (led_in) begin
          state_d = RISE;
        end else if (tick) begin
          if (level_q <= LVL_ONE) begin
            level_d = '0;
            state_d = OFF;
          end else begin
            level_d = level_q - 1'b1;
          end
        end else begin
          step_d = step_q + 1'b1;
        end
      end
    endcase
    busy_d = (state_d == RISE) || (state_d == FALL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OFF;
      level_q <= '0;
      step_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
    end
  end

`ifdef LED_FADER_GAMMA_EN
  logic [2*PWM_BITS-1:0] sq;
  assign sq   = level_q * level_q;
  assign duty = (level_q == LVL_MAX) ? LVL_MAX : PWM_BITS'(sq >> PWM_BITS);
`else
  assign duty = level_q;
`endif

  led_fader_pwm #(
    .PWM_BITS (PWM_BITS),
    .PRESC    (N_PRESC)
  ) u_pwm (
    .clk     (clk),
    .rst     (rst),
    .duty    (duty),
    .pwm_out (led_out)
  );

  assign level = level_q;
  assign busy  = busy_q;

endmodule

// File: doc/led_fader.md
Name: led_fader

Overview:
- Downstream stage of the LED blinker. Consumes its on/off `led` output and drives the physical LED pin.
- Replaces hard on/off edges with linear brightness ramps (soft fade-in / fade-out) via PWM.
- Single clock domain, same clock as the blinker, so `led_in` needs no synchronizer.

Parameters:
- CLK_FREQ_KHz, 50000, system clock frequency in kHz.
- PWM_FREQ_Hz, 1000, PWM period frequency in Hz.
- PWM_BITS, 8, brightness resolution; MAX = 2^PWM_BITS-1.
- RAMP_US, 200000, full-scale ramp time 0->MAX in microseconds.
- Derived PRESC = max(1, (CLK_FREQ_KHz*1000)/(PWM_FREQ_Hz*2^PWM_BITS)), clock cycles per PWM count.
- Derived STEP_CYCLES = max(1, (CLK_FREQ_KHz*RAMP_US/1000)/MAX), clock cycles per level step.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset: asynchronous assert, active-high.
- led_in  in  1  target LED state (blinker output).
- led_out  out  1  PWM-driven LED pin.
- level  out  PWM_BITS  current brightness.
- busy  out  1  high while state is RISE or FALL.

Behaviour:
- Reset (async, rst=1): state=OFF, level=0, duty shadow=0, prescaler=0, pwm_cnt=0, step_cnt=0, led_out=0, busy=0. Deassertion is synchronous to clk by system convention.
- Prescaler:
  - Counts 0..PRESC-1.
  - At terminal count, pwm_cnt increments mod 2^PWM_BITS.
  - pwm wrap = pwm_cnt MAX->0 at a prescaler terminal count.
- Duty shadow: latched from the mapped level on each pwm wrap only, so there are no mid-period glitches.
- led_out (registered):
  - 1 if shadow==MAX.
  - Otherwise (pwm_cnt < shadow).
  - shadow==0 gives constant 0.
- Step counter:
  - Runs only in RISE/FALL; counts 0..STEP_CYCLES-1.
  - Terminal count = step tick.
  - Cleared on every state change and in OFF/ON.
- FSM:
  - OFF: led_in=1 -> RISE.
  - RISE:
    - Step tick -> level+1.
    - level==MAX-1 with tick -> level=MAX and go to ON.
    - led_in=0 -> FALL, level held.
  - ON: led_in=0 -> FALL.
  - FALL:
    - Step tick -> level-1.
    - level==1 with tick -> level=0 and go to OFF.
    - led_in=1 -> RISE, level held.
- Simultaneous led_in reversal and step tick: the reversal wins and no step is applied that cycle.
- Level saturates and never wraps: no increment at MAX, no decrement at 0.
- Latency:
  - led_in rise -> state RISE next cycle.
  - First level increment STEP_CYCLES cycles later.
  - Full ramp = MAX*STEP_CYCLES cycles.
  - Shadow effect up to one PWM period later.
- busy = (state==RISE || state==FALL), registered alongside state.
- Reset mid-ramp: immediate OFF/level 0/led_out 0. After release, led_in=1 starts a fresh ramp from 0.

Optional Feature:
- Macro LED_FADER_GAMMA_EN.
- Defined: shadow latches (level*level)>>PWM_BITS, using a 2*PWM_BITS-bit product, with MAX forced to MAX. Gives perceptual brightness; `level` output is unaffected.
- Undefined: shadow latches level directly (linear).

Decomposition:
- Package led_fader_defs:
  - state enum {OFF, RISE, ON, FALL}, 2 bits.
  - clog2 function.
  - Derived constants PRESC, STEP_CYCLES, MAX.
  - Width constants for the prescaler and step counters.
- Sub-module led_fader_pwm:
  - Contains prescaler, pwm_cnt, duty shadow, compare.
  - Inputs: clk, rst, duty (PWM_BITS).
  - Output: pwm_out.
- Top-level led_fader holds the FSM, step counter and level register.

Test Plan (CLK_FREQ_KHz=1000, PWM_FREQ_Hz=62500, PWM_BITS=4, RAMP_US=30, giving PRESC=1, MAX=15, STEP_CYCLES=2):
- Reset check: assert rst mid-simulation without clk edge -> led_out=0, level=0, busy=0 immediately.
- Ramp up: led_in 0->1 -> busy=1 next cycle, level increments every 2 cycles, level=15 and busy=0 after 30 cycles, led_out constant 1 after the next pwm wrap.
- Ramp down: from ON, led_in=0 -> level decrements every 2 cycles to 0 in 30 cycles, then led_out constant 0.
- Reversal: led_in=1 until level=7, then led_in=0 on a step-tick cycle -> level stays 7 that cycle, then 6 two cycles later, state FALL.
- Duty check: hold level=4 (pulse led_in) -> led_out high exactly 4 of every 16 cycles, with the change only at pwm wrap.
- With LED_FADER_GAMMA_EN, level=8 -> duty 4/16; level=15 -> constant 1.
